// File: rtl/bcd_down_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Pulls an out-of-range nibble back to the largest legal BCD digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_down_timer_digit.sv
// One BCD digit of the down-counter: combinational decrement with borrow.
module bcd_digit_down
  import bcd_down_timer_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == BCD_ZERO) begin
        digit_o  = BCD_MAX;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with START/STOP/TICK control and a DONE pulse.
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  tick_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e               state_q, state_d;
  logic [4*DIGITS-1:0]  count_q, count_d;
  logic [4*DIGITS-1:0]  preset_q, preset_d;
  logic                 done_q, done_d;

  logic [4*DIGITS-1:0]  load_clamped;
  logic [4*DIGITS-1:0]  count_dec;
  logic [DIGITS:0]      borrow;
  logic                 count_zero;

  // The borrow only escapes the top digit when every digit is zero,
  // so the chain's final borrow doubles as the zero detector.
  assign borrow[0]  = 1'b1;
  assign count_zero = borrow[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign load_clamped[4*g +: 4] = bcd_clamp(load_val_i[4*g +: 4]);

    bcd_digit_down u_digit (
      .digit_i  (count_q[4*g +: 4]),
      .borrow_i (borrow[g]),
      .digit_o  (count_dec[4*g +: 4]),
      .borrow_o (borrow[g+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (start_i) begin
      preset_d = load_clamped;
      count_d  = load_clamped;
      state_d  = RUN;
    end else if (stop_i) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (tick_i && (state_q == RUN)) begin
      if (count_zero) begin
        done_d = 1'b1;
        if (AUTO_RELOAD != 0) count_d = preset_q;
        else                  state_d = EXPIRED;
      end else begin
        count_d = count_dec;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      preset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = count_zero;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;

endmodule
